lfo_ctrl: RTL and testbench
===========================

LFO_CTRL -- requirements
Module: lfo_ctrl

Interface
REQ-001 Parameter DEFAULT_FREQ, 4'd3, frequency setting applied at reset (1.0 Hz).
REQ-002 Parameter TIMEOUT_TICKS, 4096, sample ticks to wait for a zero crossing before forcing a pending change.
REQ-003 clk_i  input  1  single system clock; all logic on its rising edge.
REQ-004 rst_i  input  1  asynchronous, active-high reset.
REQ-005 sampleTick_i  input  1  one-cycle strobe at the 44.1 kHz audio sample rate.
REQ-006 cfgValid_i  input  1  requester has a new configuration on freqReq_i/scaleReq_i.
REQ-007 freqReq_i  input  4  requested LFO frequency code.
REQ-008 scaleReq_i  input  4  requested LFO depth (0=0.0, 15=1.0).
REQ-009 cfgReady_o  output  1  controller can accept a configuration this cycle.
REQ-010 wave_i  input  14 signed  LFO output sample fed back from the generator.
REQ-011 newVal_i  input  1  one-cycle strobe marking wave_i as freshly updated.
REQ-012 lfoUpdate_o  output  1  one-cycle update strobe driving the generator's FIFO update input.
REQ-013 freqSetting_o  output  4  frequency code driven to the generator.
REQ-014 scaleFactor_o  output  4  depth code driven to the generator.
REQ-015 busy_o  output  1  a configuration change is in progress.

Function
REQ-016 lfoUpdate_o SHALL equal sampleTick_i delayed by exactly one clock, independent of FSM state.
REQ-017 FSM states SHALL be IDLE, PENDING and RAMP.
REQ-018 cfgReady_o SHALL be high only in IDLE; busy_o SHALL be high exactly when not in IDLE.
REQ-019 Acceptance SHALL occur on a cycle with cfgValid_i and cfgReady_o both high; freqReq_i/scaleReq_i are latched as targets, and the FSM moves IDLE->PENDING.
REQ-020 Zero crossing SHALL be flagged on a newVal_i cycle when wave_i is zero or its sign differs from the wave_i captured on the previous newVal_i.
REQ-021 In PENDING, a zero crossing SHALL, on the next cycle, load freqSetting_o with the target and move to RAMP.
REQ-022 In PENDING, a 12-bit counter SHALL count lfoUpdate_o pulses; on reaching TIMEOUT_TICKS with no crossing, the action of REQ-021 SHALL be forced.
REQ-023 In RAMP, each lfoUpdate_o pulse SHALL step scaleFactor_o by +1 or -1 toward the target; scaleFactor_o SHALL never pass the target or wrap outside 0..15.
REQ-024 On the cycle scaleFactor_o equals the target in RAMP, the FSM SHALL return to IDLE; a target equal to the current scale SHALL go PENDING->RAMP->IDLE with no step.
REQ-025 A zero crossing and a timeout in the same cycle SHALL be treated as one crossing (single transition).
REQ-026 A sampleTick_i coinciding with acceptance SHALL still produce lfoUpdate_o; the counter SHALL start from 0 on acceptance.
REQ-027 cfgValid_i while busy SHALL be ignored (not latched); the requester holds it until cfgReady_o.
REQ-028 freqSetting_o SHALL change only on a PENDING->RAMP transition; scaleFactor_o only in RAMP.

Reset
REQ-029 While rst_i is high: state IDLE, freqSetting_o=DEFAULT_FREQ, scaleFactor_o=0, lfoUpdate_o=0, busy_o=0, cfgReady_o=1, counter=0, stored sign=0.
REQ-030 Reset asserted mid-PENDING or mid-RAMP SHALL abandon the change immediately, with no partial target retained.

Structure
REQ-031 Shared package lfo_pkg SHALL hold the FSM state typedef, DEFAULT_FREQ, TIMEOUT_TICKS, and the 14-bit wave width constant.
REQ-032 Zero-crossing detection (REQ-020) SHALL be one sub-module, lfo_zc_det; everything else is in lfo_ctrl.

Verification
REQ-033 Reset release -> freqSetting_o=3, scaleFactor_o=0, cfgReady_o=1; with sampleTick_i every 1134 clocks, each tick is followed by lfoUpdate_o exactly one clock later.
REQ-034 Accept freq=7, scale=15; wave_i goes +200 -> -150 on newVal_i -> freqSetting_o=7 next cycle; scaleFactor_o steps 0->15 over 15 ticks; then IDLE and busy_o=0.
REQ-035 From scale 15, accept scale=12 with wave_i constant at +500 -> after 4096 ticks the change is forced; scaleFactor_o 15->14->13->12 on three successive ticks.
REQ-036 Hold cfgValid_i high during RAMP with freq=2 -> not accepted until IDLE, then accepted on the first cfgReady_o cycle.
REQ-037 Assert rst_i midway through a ramp (scaleFactor_o=6, target 10) -> outputs return to reset values asynchronously; no further steps after release.
REQ-038 Accept with target equal to current values while wave_i=0 -> freqSetting_o and scaleFactor_o unchanged, busy_o high for exactly the PENDING and RAMP cycles, then IDLE.

Source files
------------

// File: rtl/lfo_pkg.sv
// Shared types and constants for the LFO configuration controller.
// Holds the FSM state encoding, reset defaults and the wave sample width.
package lfo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_RAMP    = 2'd2
  } lfo_state_e;

  localparam logic [3:0] DEFAULT_FREQ  = 4'd3;
  localparam int         TIMEOUT_TICKS = 4096;
  localparam int         WAVE_W        = 14;
  localparam int         CNT_W         = 12;
  localparam int         CODE_W        = 4;

endpackage

// File: rtl/lfo_zc_det.sv
// Zero-crossing detector on the generator feedback sample.
// Flags a crossing when a fresh sample is zero or flips sign against the previous fresh sample.
module lfo_zc_det
  import lfo_pkg::*;
#(
  parameter int DATA_W = WAVE_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     newVal_i,
  input  logic signed [DATA_W-1:0] wave_i,
  output logic                     zc_o
);

  logic signQ_q;
  logic signQ_d;
  logic waveNeg;
  logic waveZero;

  assign waveNeg  = wave_i[DATA_W-1];
  assign waveZero = (wave_i == '0);

  always_comb begin
    signQ_d = signQ_q;
    if (newVal_i) begin
      signQ_d = waveNeg;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      signQ_q <= 1'b0;
    end else begin
      signQ_q <= signQ_d;
    end
  end

  assign zc_o = newVal_i && (waveZero || (waveNeg != signQ_q));

endmodule

// File: rtl/lfo_ctrl.sv
// LFO configuration controller: accepts a new frequency/depth, waits for a zero crossing
// (or a tick timeout) to switch frequency, then ramps depth one step per update tick.
module lfo_ctrl
  import lfo_pkg::*;
#(
  parameter logic [3:0] DEFAULT_FREQ  = lfo_pkg::DEFAULT_FREQ,
  parameter int         TIMEOUT_TICKS = lfo_pkg::TIMEOUT_TICKS
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     sampleTick_i,
  input  logic                     cfgValid_i,
  input  logic [CODE_W-1:0]        freqReq_i,
  input  logic [CODE_W-1:0]        scaleReq_i,
  output logic                     cfgReady_o,
  input  logic signed [WAVE_W-1:0] wave_i,
  input  logic                     newVal_i,
  output logic                     lfoUpdate_o,
  output logic [CODE_W-1:0]        freqSetting_o,
  output logic [CODE_W-1:0]        scaleFactor_o,
  output logic                     busy_o
);

  // The counter holds TIMEOUT_TICKS-1 when the final pulse arrives, so 4096 fits in 12 bits.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_TICKS - 1);

  lfo_state_e          state_q, state_d;
  logic [CODE_W-1:0]   tgtFreq_q, tgtFreq_d;
  logic [CODE_W-1:0]   tgtScale_q, tgtScale_d;
  logic [CODE_W-1:0]   freq_q, freq_d;
  logic [CODE_W-1:0]   scale_q, scale_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                lfoUpdate_q;
  logic                zc;
  logic                timeout;
  logic                goRamp;
  logic                atTarget;

  function automatic logic [CODE_W-1:0] step_toward(input logic [CODE_W-1:0] cur,
                                                    input logic [CODE_W-1:0] tgt);
    logic [CODE_W-1:0] nxt;
    nxt = cur;
    if (cur < tgt) begin
      nxt = cur + 4'd1;
    end else if (cur > tgt) begin
      nxt = cur - 4'd1;
    end
    return nxt;
  endfunction

  lfo_zc_det #(
    .DATA_W (WAVE_W)
  ) u_zc (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .newVal_i (newVal_i),
    .wave_i   (wave_i),
    .zc_o     (zc)
  );

  assign timeout  = (state_q == ST_PENDING) && lfoUpdate_q && (cnt_q == TO_LAST);
  assign goRamp   = (state_q == ST_PENDING) && (zc || timeout);
  assign atTarget = (scale_q == tgtScale_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (cfgValid_i) state_d = ST_PENDING;
      ST_PENDING: if (goRamp)     state_d = ST_RAMP;
      ST_RAMP:    if (atTarget)   state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cfgReady_o = (state_q == ST_IDLE);
    busy_o     = (state_q != ST_IDLE);
  end

  always_comb begin
    tgtFreq_d  = tgtFreq_q;
    tgtScale_d = tgtScale_q;
    freq_d     = freq_q;
    scale_d    = scale_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (cfgValid_i) begin
          tgtFreq_d  = freqReq_i;
          tgtScale_d = scaleReq_i;
          cnt_d      = '0;
        end
      end
      ST_PENDING: begin
        if (lfoUpdate_q) begin
          cnt_d = cnt_q + 12'd1;
        end
        if (goRamp) begin
          freq_d = tgtFreq_q;
        end
      end
      ST_RAMP: begin
        if (!atTarget && lfoUpdate_q) begin
          scale_d = step_toward(scale_q, tgtScale_q);
        end
      end
      default: ;
    endcase
  end

  // Targets are cleared too, so an interrupted change leaves nothing behind.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tgtFreq_q   <= DEFAULT_FREQ;
      tgtScale_q  <= '0;
      freq_q      <= DEFAULT_FREQ;
      scale_q     <= '0;
      cnt_q       <= '0;
      lfoUpdate_q <= 1'b0;
    end else begin
      tgtFreq_q   <= tgtFreq_d;
      tgtScale_q  <= tgtScale_d;
      freq_q      <= freq_d;
      scale_q     <= scale_d;
      cnt_q       <= cnt_d;
      lfoUpdate_q <= sampleTick_i;
    end
  end

  assign lfoUpdate_o   = lfoUpdate_q;
  assign freqSetting_o = freq_q;
  assign scaleFactor_o = scale_q;

endmodule

// File: tb/tb_lfo_ctrl.sv
// Bench for lfo_ctrl: table vectors, directed corner sequences and random traffic,
// all compared cycle by cycle against an integer-level reference model.
module tb_lfo_ctrl;
  import lfo_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     tick = 1'b0;
  logic                     cv = 1'b0;
  logic [3:0]               freq = '0;
  logic [3:0]               scale = '0;
  logic                     ready;
  logic signed [WAVE_W-1:0] wave = '0;
  logic                     nv = 1'b0;
  logic                     lfoUpdate_o;
  logic [3:0]               freqSetting_o;
  logic [3:0]               scaleFactor_o;
  logic                     busy_o;

  always #5 clk = ~clk;

  lfo_ctrl dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .sampleTick_i  (tick),
    .cfgValid_i    (cv),
    .freqReq_i     (freq),
    .scaleReq_i    (scale),
    .cfgReady_o    (ready),
    .wave_i        (wave),
    .newVal_i      (nv),
    .lfoUpdate_o   (lfoUpdate_o),
    .freqSetting_o (freqSetting_o),
    .scaleFactor_o (scaleFactor_o),
    .busy_o        (busy_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0=idle, 1=waiting for crossing, 2=ramping
  int m_mode, m_freq, m_scale, m_tf, m_ts, m_wait;
  bit m_upd, m_prevNeg;

  typedef struct {
    bit cv; int f; int s; bit tk; bit nv; int w;
    bit eUpd; bit eRdy; bit eBusy; int eFreq; int eScale;
  } vec_t;
  vec_t vecs[13];

  function automatic logic [10:0] pack(input bit u, input bit r, input bit b, input int f, input int s);
    return {u, r, b, 4'(f), 4'(s)};
  endfunction

  function automatic logic [10:0] dut_vec();
    return {lfoUpdate_o, ready, busy_o, freqSetting_o, scaleFactor_o};
  endfunction

  function automatic logic [10:0] model_vec();
    return pack(m_upd, m_mode == 0, m_mode != 0, m_freq, m_scale);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_freq = 3; m_scale = 0; m_tf = 3; m_ts = 0;
    m_wait = 0; m_upd = 0; m_prevNeg = 0;
  endtask

  task automatic model_clock();
    int  nm;
    bit  neg, zc;
    nm  = m_mode;
    neg = (wave < 0);
    zc  = nv && ((wave == 0) || (neg != m_prevNeg));
    if (nv) m_prevNeg = neg;
    case (m_mode)
      0: if (cv) begin
        m_tf = int'(freq); m_ts = int'(scale); m_wait = 0; nm = 1;
      end
      1: begin
        if (m_upd) m_wait++;
        if (zc || (m_wait == TIMEOUT_TICKS)) begin
          m_freq = m_tf; nm = 2;
        end
      end
      default: begin
        if (m_scale == m_ts) nm = 0;
        else if (m_upd) m_scale += (m_ts > m_scale) ? 1 : -1;
      end
    endcase
    m_mode = nm;
    m_upd  = tick;
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    chk("cycle", int'(dut_vec()), int'(model_vec()));
  endtask

  task automatic cyc(input bit v, input int f, input int s, input bit tk, input bit n, input int w);
    cv = v; freq = 4'(f); scale = 4'(s); tick = tk; nv = n; wave = 14'(w);
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1; cv = 0; freq = 0; scale = 0; tick = 0; nv = 0; wave = 0;
    model_reset();
    #1;
    chk("rst_async", int'(dut_vec()), int'(pack(0, 1, 0, 3, 0)));
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold", int'(dut_vec()), int'(pack(0, 1, 0, 3, 0)));
    rst = 1'b0;
  endtask

  initial begin
    int cnt, prev, found;
    int seq[$];

    vecs[0]  = '{1, 3, 2, 1, 0,   0, 1, 0, 1, 3, 0};
    vecs[1]  = '{0, 0, 0, 0, 1, 100, 0, 0, 1, 3, 0};
    vecs[2]  = '{0, 0, 0, 0, 1,   0, 0, 0, 1, 3, 0};
    vecs[3]  = '{0, 0, 0, 1, 0,   0, 1, 0, 1, 3, 0};
    vecs[4]  = '{0, 0, 0, 0, 0,   0, 0, 0, 1, 3, 1};
    vecs[5]  = '{0, 0, 0, 1, 0,   0, 1, 0, 1, 3, 1};
    vecs[6]  = '{0, 0, 0, 0, 0,   0, 0, 0, 1, 3, 2};
    vecs[7]  = '{0, 0, 0, 0, 0,   0, 0, 1, 0, 3, 2};
    vecs[8]  = '{1, 9, 2, 0, 1,  -5, 0, 0, 1, 3, 2};
    vecs[9]  = '{0, 0, 0, 0, 1,  -7, 0, 0, 1, 3, 2};
    vecs[10] = '{0, 0, 0, 0, 1,   3, 0, 0, 1, 9, 2};
    vecs[11] = '{0, 0, 0, 0, 0,   0, 0, 1, 0, 9, 2};
    vecs[12] = '{0, 0, 0, 1, 0,   0, 1, 1, 0, 9, 2};

    #2;
    do_reset();

    foreach (vecs[i]) begin
      cyc(vecs[i].cv, vecs[i].f, vecs[i].s, vecs[i].tk, vecs[i].nv, vecs[i].w);
      chk($sformatf("vec%0d", i), int'(dut_vec()),
          int'(pack(vecs[i].eUpd, vecs[i].eRdy, vecs[i].eBusy, vecs[i].eFreq, vecs[i].eScale)));
    end

    // Audio-rate ticks: one update strobe exactly one clock after each tick
    do_reset();
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < 1134; k++) begin
        cyc(0, 0, 0, k == 0, 0, 0);
        if (k == 0) chk("upd_after_tick", int'(lfoUpdate_o), 1);
        if (k == 1) chk("upd_one_clock", int'(lfoUpdate_o), 0);
      end
    end

    // Crossing-triggered change, then full depth ramp 0 -> 15
    cyc(0, 0, 0, 0, 1, 200);
    cyc(1, 7, 15, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 200);
    chk("no_zc_freq", int'(freqSetting_o), 3);
    cyc(0, 0, 0, 0, 1, -150);
    chk("zc_freq", int'(freqSetting_o), 7);
    cnt = 0; prev = int'(scaleFactor_o); found = 0;
    for (int i = 0; i < 400; i++) begin
      cyc(0, 0, 0, (i % 3) == 0, 0, 0);
      if (int'(scaleFactor_o) != prev) cnt++;
      prev = int'(scaleFactor_o);
      if (!busy_o) begin found = 1; break; end
    end
    chk("ramp_done", found, 1);
    chk("ramp_steps", cnt, 15);
    chk("ramp_final", int'(scaleFactor_o), 15);

    // Timeout: wave stays positive, change forced after TIMEOUT_TICKS update pulses
    cyc(0, 0, 0, 0, 1, 500);
    cyc(1, 5, 12, 0, 1, 500);
    cnt = 0; found = 0;
    for (int i = 0; i < 20000; i++) begin
      if (freqSetting_o == 4'd5) begin found = 1; break; end
      cnt += int'(lfoUpdate_o);
      cyc(0, 0, 0, (i % 2) == 0, 1, 500);
    end
    chk("timeout_hit", found, 1);
    chk("timeout_pulses", cnt, TIMEOUT_TICKS);
    prev = int'(scaleFactor_o); found = 0;
    for (int i = 0; i < 200; i++) begin
      cyc(0, 0, 0, (i % 4) == 0, 0, 0);
      if (int'(scaleFactor_o) != prev) seq.push_back(int'(scaleFactor_o));
      prev = int'(scaleFactor_o);
      if (!busy_o) begin found = 1; break; end
    end
    chk("down_done", found, 1);
    chk("down_len", seq.size(), 3);
    if (seq.size() == 3) begin
      chk("down_s0", seq[0], 14);
      chk("down_s1", seq[1], 13);
      chk("down_s2", seq[2], 12);
    end

    // Request held during a ramp is taken on the first ready cycle
    cyc(1, 4, 8, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("ramp2_freq", int'(freqSetting_o), 4);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      cyc(1, 2, 1, (i % 2) == 0, 0, 0);
      if (ready) begin found = 1; break; end
    end
    chk("held_ready", found, 1);
    chk("held_not_taken", int'(freqSetting_o), 4);
    chk("held_scale", int'(scaleFactor_o), 8);
    cyc(1, 2, 1, 0, 0, 0);
    chk("held_accept", int'(busy_o), 1);
    cyc(0, 0, 0, 0, 1, 0);
    chk("held_freq", int'(freqSetting_o), 2);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      cyc(0, 0, 0, (i % 2) == 0, 0, 0);
      if (!busy_o) begin found = 1; break; end
    end
    chk("held_done", found, 1);
    chk("held_final", int'(scaleFactor_o), 1);

    // Asynchronous reset in the middle of a ramp
    cyc(1, 6, 10, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      cyc(0, 0, 0, (i % 2) == 0, 0, 0);
      if (scaleFactor_o == 4'd6) begin found = 1; break; end
    end
    chk("mid_reach6", found, 1);
    chk("mid_busy", int'(busy_o), 1);
    #2 rst = 1'b1;
    #1 chk("mid_async_rst", int'(dut_vec()), int'(pack(0, 1, 0, 3, 0)));
    model_reset();
    tick = 0; cv = 0; nv = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 30; i++) cyc(0, 0, 0, (i % 2) == 0, (i % 5) == 0, 0);
    chk("post_rst_scale", int'(scaleFactor_o), 0);
    chk("post_rst_busy", int'(busy_o), 0);

    // Target equal to current settings with a zero sample
    cyc(1, 3, 0, 0, 0, 0);
    cnt = 0; found = 0;
    for (int i = 0; i < 20; i++) begin
      if (!busy_o) begin found = 1; break; end
      cnt++;
      cyc(0, 0, 0, 1, 1, 0);
    end
    chk("same_done", found, 1);
    chk("same_busy_cycles", cnt, 2);
    chk("same_vals", int'(dut_vec()), int'(pack(1, 1, 0, 3, 0)));

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      int w;
      w = ($urandom_range(0, 7) == 0) ? 0 : (int'($urandom_range(0, 4000)) - 2000);
      cyc($urandom_range(0, 3) == 0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
          $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, w);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
